// File: rtl/imem_loadable.sv
// Byte-addressed little-endian instruction memory: registered 32-bit fetch port plus byte-serial load port.
// Optional IMEM_DEFAULT_PROG_EN: reset enters RUN with a built-in 7-word program in bytes 0..27.
module imem_loadable #(
  parameter int DEPTH_BYTES = 64,
  parameter int PC_W        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req,
  input  logic [PC_W-1:0]              PC,
  output logic                         fetch_ready,
  output logic [31:0]                  Instruction_Code,
  output logic                         inst_valid,
  output logic                         inst_fault,
  input  logic                         load_start,
  input  logic                         ld_valid,
  input  logic [7:0]                   ld_byte,
  input  logic                         ld_last,
  output logic                         ld_ready,
  output logic                         load_err,
  output logic [$clog2(DEPTH_BYTES):0] load_count
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;

  typedef enum logic {LOAD, RUN} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q, vld_q, flt_q;
  logic [31:0]   code_q;
  logic [7:0]    mem_q [DEPTH_BYTES];

  logic          ld_hs, full, wr_en, fetch_acc, pc_fault;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  assign ld_ready    = (state_q == LOAD);
  assign fetch_ready = (state_q == RUN) && !load_start;
  assign ld_hs       = ld_valid & ld_ready;
  assign full        = (cnt_q == CW'(DEPTH_BYTES));
  assign wr_en       = ld_hs & !full;
  assign fetch_acc   = fetch_req & fetch_ready;

  // Unsigned compare at full PC width so high PCs fault instead of aliasing.
  assign pc_fault = (PC[1:0] != 2'b00) || (PC > PC_W'(DEPTH_BYTES - 4));
  assign rd_idx   = PC[AW-1:0];
  assign rd_word  = {mem_q[AW'(rd_idx + AW'(3))], mem_q[AW'(rd_idx + AW'(2))],
                     mem_q[AW'(rd_idx + AW'(1))], mem_q[rd_idx]};

  assign Instruction_Code = code_q;
  assign inst_valid       = vld_q;
  assign inst_fault       = flt_q;
  assign load_err         = err_q;
  assign load_count       = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef IMEM_DEFAULT_PROG_EN
      state_q <= RUN;
      cnt_q   <= CW'(28);
`else
      state_q <= LOAD;
      cnt_q   <= '0;
`endif
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      vld_q <= fetch_acc;
      if (fetch_acc) begin
        flt_q  <= pc_fault;
        code_q <= pc_fault ? 32'h0 : rd_word;
      end
      case (state_q)
        LOAD: if (ld_hs) begin
          if (full) err_q <= 1'b1;
          else      cnt_q <= cnt_q + CW'(1);
          if (ld_last) state_q <= RUN;
        end
        RUN: if (load_start) begin
          state_q <= LOAD;
          cnt_q   <= '0;
          err_q   <= 1'b0;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

`ifdef IMEM_DEFAULT_PROG_EN
  localparam logic [31:0] DEF_PROG [7] = '{32'h00011020, 32'h00853022, 32'h01095024,
                                          32'h01285025, 32'h01660180, 32'h01A90282,
                                          32'hFC200008};

  // Only bytes 0..27 are forced; the rest of the array keeps its contents through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < 7; w++)
        for (int b = 0; b < 4; b++)
          mem_q[4*w+b] <= DEF_PROG[w][8*b +: 8];
    end else if (wr_en) begin
      mem_q[cnt_q[AW-1:0]] <= ld_byte;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[AW-1:0]] <= ld_byte;
  end
`endif
endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: directed loads and fetches, monitor pops expected responses on inst_valid.
module tb_imem_loadable;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   PC = '0;
  logic          fetch_ready;
  logic [31:0]   Instruction_Code;
  logic          inst_valid, inst_fault;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready, load_err;
  logic [CW-1:0] load_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];

  imem_loadable #(.DEPTH_BYTES(DEPTH), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .PC(PC),
    .fetch_ready(fetch_ready), .Instruction_Code(Instruction_Code),
    .inst_valid(inst_valid), .inst_fault(inst_fault),
    .load_start(load_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready), .load_err(load_err),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (inst_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got code=%h fault=%b, required no response",
                 Instruction_Code, inst_fault);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({inst_fault, Instruction_Code} !== e) begin
          errors++;
          $display("FAIL fetch_resp: got fault=%b code=%h, required fault=%b code=%h",
                   inst_fault, Instruction_Code, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic f, input logic [31:0] code);
    fetch_req = 1'b1;
    PC        = pc;
    exp_q.push_back({f, code});
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    #1;
    chk("fetch_ready_blocked", {31'b0, fetch_ready}, 32'd0);
    cyc();
    load_start = 1'b0;
    chk("ld_ready_after_start", {31'b0, ld_ready}, 32'd1);
    chk("count_cleared", 32'(load_count), 32'd0);
  endtask

  initial begin
    logic [7:0] prog8 [8];
    prog8 = '{8'h20, 8'h10, 8'h01, 8'h00, 8'h22, 8'h30, 8'h85, 8'h00};

    #12;
`ifdef IMEM_DEFAULT_PROG_EN
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("rst_count", 32'(load_count), 32'd28);
`else
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
`endif
    chk("rst_err", {31'b0, load_err}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, inst_fault}, 32'd0);
    chk("rst_code", Instruction_Code, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

`ifdef IMEM_DEFAULT_PROG_EN
    fetch(32'd0,  1'b0, 32'h00011020);
    fetch(32'd4,  1'b0, 32'h00853022);
    fetch(32'd8,  1'b0, 32'h01095024);
    fetch(32'd12, 1'b0, 32'h01285025);
    fetch(32'd16, 1'b0, 32'h01660180);
    fetch(32'd20, 1'b0, 32'h01A90282);
    fetch(32'd24, 1'b0, 32'hFC200008);
    cyc();
    pulse_load_start();
`endif

    for (int i = 0; i < 8; i++) send(prog8[i], i == 7);
    chk("run_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("run_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("count_8", 32'(load_count), 32'd8);

    fetch(32'd4, 1'b0, 32'h00853022);
    fetch(32'd0, 1'b0, 32'h00011020);
    fetch(32'd2, 1'b1, 32'h0);
    fetch(32'(DEPTH - 2), 1'b1, 32'h0);
    fetch(32'(DEPTH), 1'b1, 32'h0);
    fetch(32'hFFFF_FFFC, 1'b1, 32'h0);
    fetch(32'd4, 1'b0, 32'h00853022);
    cyc();
    cyc();
    chk("hold_valid_low", {31'b0, inst_valid}, 32'd0);
    chk("hold_code", Instruction_Code, 32'h00853022);

    // Overflow: two extra bytes past the end must be dropped, not wrapped onto byte 0.
    pulse_load_start();
    for (int i = 0; i < DEPTH + 2; i++)
      send((i < DEPTH) ? (8'(i) ^ 8'hA5) : 8'hEE, i == DEPTH + 1);
    chk("ovf_err", {31'b0, load_err}, 32'd1);
    chk("ovf_count", 32'(load_count), 32'(DEPTH));
    chk("ovf_run", {31'b0, fetch_ready}, 32'd1);
    fetch(32'd0, 1'b0, 32'hA6A7A4A5);
    fetch(32'(DEPTH - 4), 1'b0, 32'h9A9B9899);
    cyc();

    load_start = 1'b1;
    fetch_req  = 1'b1;
    PC         = 32'd0;
    cyc();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    chk("ls_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("ls_err_cleared", {31'b0, load_err}, 32'd0);
    chk("ls_count", 32'(load_count), 32'd0);
    @(negedge clk);
    chk("ls_no_valid", {31'b0, inst_valid}, 32'd0);
    cyc();

    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("partial_count", 32'(load_count), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
`ifdef IMEM_DEFAULT_PROG_EN
    chk("mid_rst_count", 32'(load_count), 32'd28);
    chk("mid_rst_state", {31'b0, ld_ready}, 32'd0);
`else
    chk("mid_rst_count", 32'(load_count), 32'd0);
    chk("mid_rst_state", {31'b0, ld_ready}, 32'd1);
`endif
    cyc();
    reset = 1'b1;
    cyc();

`ifdef IMEM_DEFAULT_PROG_EN
    fetch(32'd4,  1'b0, 32'h00853022);
    fetch(32'd28, 1'b0, 32'hBABBB8B9);
    cyc();
    pulse_load_start();
`endif
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    fetch(32'd0, 1'b0, 32'h44332211);
`ifndef IMEM_DEFAULT_PROG_EN
    fetch(32'd4, 1'b0, 32'hA2A3A0A1);
`endif
    cyc();

    // Reset landing just after an accepted fetch must kill the pending response.
    fetch_req = 1'b1;
    PC        = 32'd0;
    cyc();
    fetch_req = 1'b0;
    chk("pend_valid", {31'b0, inst_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("pend_cancel", {31'b0, inst_valid}, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, byte-addressed, little-endian instruction memory with a registered fetch port and a byte-serial program-load port. It sits between the PC register and the decoder. The program is streamed in after reset, or at any later time, through a valid/ready handshake. Fetch returns a 32-bit instruction one cycle after request, and flags misaligned or out-of-range PCs instead of returning garbage.

## Interface
- DEPTH_BYTES, 64, memory size in bytes; must be a multiple of 4 and at least 32
- PC_W, 32, PC width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request, sampled when fetch_ready=1
- PC  in  PC_W  byte address of the instruction
- fetch_ready  out  1  fetch port can accept a request
- Instruction_Code  out  32  registered instruction {Mem[PC+3],Mem[PC+2],Mem[PC+1],Mem[PC]}
- inst_valid  out  1  Instruction_Code/inst_fault valid for this cycle (single-cycle pulse per request)
- inst_fault  out  1  the returned fetch was misaligned or out of range
- load_start  in  1  pulse; in RUN, begins a new program load
- ld_valid  in  1  ld_byte valid
- ld_byte  in  8  program byte, written to consecutive addresses from 0
- ld_last  in  1  marks the final byte of the program
- ld_ready  out  1  load port accepts a byte
- load_err  out  1  sticky: a byte arrived after the memory was full
- load_count  out  clog2(DEPTH_BYTES)+1  bytes written in the current/last load

## Operation
- FSM with two states: LOAD and RUN.
- LOAD:
  - ld_ready=1, fetch_ready=0.
  - Each handshake (ld_valid&ld_ready) writes ld_byte at load_count, then increments load_count.
  - A handshake with ld_last=1 moves the FSM to RUN.
- Load overflow: handshake with load_count==DEPTH_BYTES -> byte dropped, load_count saturates, load_err=1. Completing via ld_last is still honoured.
- RUN:
  - ld_ready=0.
  - fetch_ready=!load_start (combinational).
  - load_start=1 -> next state LOAD, load_count cleared, load_err cleared.
  - load_start has priority: a fetch_req in the same cycle is not accepted.
  - Memory is not cleared; unloaded bytes keep their old contents.
- Fetch accept (fetch_req&fetch_ready):
  - Fault if PC[1:0]!=0 or PC>DEPTH_BYTES-4. PC arithmetic is unsigned PC_W; no wrap.
  - No fault -> Instruction_Code = 4 bytes little-endian, inst_fault=0.
  - Fault -> Instruction_Code=32'h0000_0000, inst_fault=1.
- fetch_req while fetch_ready=0 is ignored; no response is queued.
- Reset clears control state only, not the memory array (except under macro, see Configuration).

## Timing
- Reset values:
  - state=LOAD, load_count=0, load_err=0
  - inst_valid=0, inst_fault=0, Instruction_Code=0
  - ld_ready=1, fetch_ready=0
- Fetch latency is 1 cycle. Request accepted at edge N -> inst_valid=1 with data for cycle N+1 only.
- Back-to-back fetches give one result per cycle.
- Instruction_Code holds its last value while inst_valid=0.
- Final load byte (ld_last) accepted at edge N -> RUN from N, so fetch_ready=1 in cycle N+1.
- A byte written at edge N is visible to a fetch accepted at edge N+1 or later.
- Reset asserted mid-load or mid-fetch:
  - immediate return to reset values
  - any pending inst_valid is cancelled
  - a partial load is abandoned

## Configuration
- IMEM_DEFAULT_PROG_EN defined:
  - Reset enters RUN, with load_count=28 and fetch_ready=1.
  - While reset is low, bytes 0..27 are forced to the default program, little-endian words: 0x00011020, 0x00853022, 0x01095024, 0x01285025, 0x01660180, 0x01A90282, 0xFC200008.
  - Other bytes are untouched.
  - load_start still allows reloading.
- Not defined: reset enters LOAD; no array initialisation (no reset logic on the array).

## Test plan
- Macro off: reset, stream 8 bytes 20,10,01,00,22,30,85,00 (ld_last on the 8th) -> fetch PC=4 returns 0x00853022 one cycle later, inst_fault=0, load_count=8.
- Macro on: release reset, fetch PC=0,4,...,24 back-to-back -> seven consecutive inst_valid pulses, ending 0xFC200008.
- Fetch PC=2, then PC=DEPTH_BYTES-2 -> inst_valid=1, inst_fault=1, Instruction_Code=0 for each.
- Stream DEPTH_BYTES+2 bytes, ld_last on the last -> load_err=1, load_count=DEPTH_BYTES, state RUN, byte 0 unchanged by the overflow.
- In RUN, assert load_start and fetch_req together -> no inst_valid next cycle, ld_ready=1, load_err cleared.
- Pull reset low mid-load after 3 bytes -> load_count=0, inst_valid=0 immediately (asynchronous), state per macro.
